ecc_secded_pipe_decoder: RTL and testbench

//  Parametrised, pipelined SECDED (Hamming + overall parity) decoder for the memory read path.

---
 rtl/ecc_pkg.sv | 60 ++++++
 rtl/ecc_syndrome_calc.sv | 28 ++
 rtl/ecc_secded_pipe_decoder.sv | 186 ++++++++++++++++++
 tb/tb_ecc_secded_pipe_decoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared SECDED helpers for the memory read-path decoder.
// Codeword positions run 1..DATA_W+ECC_W-1; check bit i sits at 2^i and
// data bits fill the remaining positions in ascending order.
package ecc_pkg;

  // Number of Hamming check bits needed to cover data_w payload bits.
  function automatic int hamming_bits(input int data_w);
    int r;
    r = 0;
    for (int k = 0; k < 30; k++) begin
      if ((1 << r) < data_w + r + 1) r = r + 1;
    end
    return r;
  endfunction

  // Full check width including the overall parity bit.
  function automatic int ecc_width(input int data_w);
    return hamming_bits(data_w) + 1;
  endfunction

  // Highest codeword position used by the Hamming part of the code.
  function automatic int max_pos(input int data_w);
    return data_w + ecc_width(data_w) - 1;
  endfunction

  // Codeword position of data bit i: start at i+1 and skip every power of two
  // at or below the running position.
  function automatic int data_pos(input int i);
    int pos;
    pos = i + 1;
    for (int k = 0; k < 30; k++) begin
      if ((1 << k) <= pos) pos = pos + 1;
    end
    return pos;
  endfunction

  localparam int DEF_DATA_W = 64;
  localparam int MAX_POS    = max_pos(DEF_DATA_W);

  // Syndrome classification.
  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_CORR   = 2'd1,
    ERR_UNCORR = 2'd2
  } err_class_e;

  // Classify a {parity, syndrome} pair against the last valid position.
  function automatic err_class_e classify(input logic par, input int syn, input int last_pos);
    err_class_e c;
    if (!par) begin
      if (syn == 0) c = ERR_NONE;
      else          c = ERR_UNCORR;
    end else begin
      if (syn <= last_pos) c = ERR_CORR;
      else                 c = ERR_UNCORR;
    end
    return c;
  endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// ecc_syndrome_calc: combinational Hamming syndrome and overall parity of a
// {ecc, data} codeword. Syndrome is the XOR of the positions of all set bits.
module ecc_syndrome_calc
  import ecc_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ECC_W  = ecc_width(DATA_W)
) (
  input  logic [DATA_W+ECC_W-1:0] code,
  output logic [ECC_W-2:0]        syn,
  output logic                    par
);

  localparam int SW = ECC_W - 1;

  // Fold every set data bit and check bit into the syndrome.
  always_comb begin
    syn = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (code[i]) syn = syn ^ SW'(data_pos(i));
    end
    for (int j = 0; j < SW; j++) begin
      if (code[DATA_W+j]) syn = syn ^ SW'(1 << j);
    end
    par = ^code;
  end

endmodule

// File: rtl/ecc_secded_pipe_decoder.sv
// ecc_secded_pipe_decoder: two-stage SECDED decoder with valid/ready flow
// control and saturating error counters.
// S1 captures data/tag/syndrome, S2 captures corrected data and flags.
// Optional error log: define ECC_ERR_LOG_EN to capture the first
// uncorrectable word (tag + syndrome) until log_clr; otherwise the log
// outputs are tied low and log_clr has no effect.
module ecc_secded_pipe_decoder
  import ecc_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 16,
  parameter int CNT_W  = 16,
  parameter int ECC_W  = ecc_width(DATA_W)
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W+ECC_W-1:0] in_code,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_corrected,
  output logic                    out_uncorrectable,
  output logic [ECC_W-1:0]        out_syndrome,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        cnt_corrected,
  output logic [CNT_W-1:0]        cnt_uncorrectable,
  input  logic                    log_clr,
  output logic                    log_valid,
  output logic [TAG_W-1:0]        log_tag,
  output logic [ECC_W-1:0]        log_syndrome
);

  localparam int SW       = ECC_W - 1;
  localparam int LAST_POS = max_pos(DATA_W);

  logic              adv1, adv2, xfer;
  logic [SW-1:0]     in_syn;
  logic              in_par;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [TAG_W-1:0]  s1_tag;
  logic [SW-1:0]     s1_syn;
  logic              s1_par;

  err_class_e        s1_cls;
  logic [DATA_W-1:0] fix_data;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_data;
  logic [TAG_W-1:0]  s2_tag;
  logic              s2_corr, s2_unc;
  logic [ECC_W-1:0]  s2_syn;

  logic [CNT_W-1:0]  cnt_corr_q, cnt_unc_q;

  assign adv2     = !s2_valid | out_ready;
  assign adv1     = !s1_valid | adv2;
  assign in_ready = adv1;
  assign xfer     = s2_valid & out_ready;

  ecc_syndrome_calc #(
    .DATA_W (DATA_W),
    .ECC_W  (ECC_W)
  ) u_syn (
    .code (in_code),
    .syn  (in_syn),
    .par  (in_par)
  );

  // S1: capture raw data, tag and syndrome when the stage can advance.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_tag   <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_code[DATA_W-1:0];
        s1_tag  <= in_tag;
        s1_syn  <= in_syn;
        s1_par  <= in_par;
      end
    end
  end

  // Classify and flip the addressed data bit; check-bit and overall-bit
  // errors match no data position and leave the payload untouched.
  always_comb begin
    s1_cls   = classify(s1_par, int'(s1_syn), LAST_POS);
    fix_data = s1_data;
    if (s1_cls == ERR_CORR) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (s1_syn == SW'(data_pos(i))) fix_data[i] = ~s1_data[i];
      end
    end
  end

  // S2: output register, held while downstream stalls.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
      s2_corr  <= 1'b0;
      s2_unc   <= 1'b0;
      s2_syn   <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= fix_data;
        s2_tag  <= s1_tag;
        s2_corr <= (s1_cls == ERR_CORR);
        s2_unc  <= (s1_cls == ERR_UNCORR);
        s2_syn  <= {s1_par, s1_syn};
      end
    end
  end

  assign out_valid         = s2_valid;
  assign out_data          = s2_data;
  assign out_tag           = s2_tag;
  assign out_corrected     = s2_corr;
  assign out_uncorrectable = s2_unc;
  assign out_syndrome      = s2_syn;

  // Saturating statistics, counted on output transfers; clear has priority.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_corr_q <= '0;
      cnt_unc_q  <= '0;
    end else if (cnt_clr) begin
      cnt_corr_q <= '0;
      cnt_unc_q  <= '0;
    end else begin
      if (xfer && s2_corr && (cnt_corr_q != '1)) cnt_corr_q <= cnt_corr_q + CNT_W'(1);
      if (xfer && s2_unc  && (cnt_unc_q  != '1)) cnt_unc_q  <= cnt_unc_q  + CNT_W'(1);
    end
  end

  assign cnt_corrected     = cnt_corr_q;
  assign cnt_uncorrectable = cnt_unc_q;

`ifdef ECC_ERR_LOG_EN
  logic             log_valid_q;
  logic [TAG_W-1:0] log_tag_q;
  logic [ECC_W-1:0] log_syn_q;
  logic             unc_xfer;

  assign unc_xfer = xfer & s2_unc;

  // First uncorrectable transfer is latched; log_clr re-arms, and a
  // same-cycle uncorrectable transfer becomes the new entry.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      log_valid_q <= 1'b0;
      log_tag_q   <= '0;
      log_syn_q   <= '0;
    end else if (unc_xfer && (log_clr || !log_valid_q)) begin
      log_valid_q <= 1'b1;
      log_tag_q   <= s2_tag;
      log_syn_q   <= s2_syn;
    end else if (log_clr) begin
      log_valid_q <= 1'b0;
    end
  end

  assign log_valid    = log_valid_q;
  assign log_tag      = log_tag_q;
  assign log_syndrome = log_syn_q;
`else
  logic log_clr_unused;
  assign log_clr_unused = log_clr;
  assign log_valid      = 1'b0;
  assign log_tag        = '0;
  assign log_syndrome   = '0;
`endif

endmodule

// File: tb/tb_ecc_secded_pipe_decoder.sv
module tb_ecc_secded_pipe_decoder;

  localparam int DW = 64;
  localparam int TW = 16;
  localparam int CW = 2;
  localparam int EW = 8;

`ifdef ECC_ERR_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW+EW-1:0] in_code = '0;
  logic [TW-1:0]    in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_data;
  logic [TW-1:0]    out_tag;
  logic             out_corrected;
  logic             out_uncorrectable;
  logic [EW-1:0]    out_syndrome;
  logic             cnt_clr = 1'b0;
  logic [CW-1:0]    cnt_corrected;
  logic [CW-1:0]    cnt_uncorrectable;
  logic             log_clr = 1'b0;
  logic             log_valid;
  logic [TW-1:0]    log_tag;
  logic [EW-1:0]    log_syndrome;

  int checks = 0;
  int failures = 0;

  ecc_secded_pipe_decoder #(
    .DATA_W (DW),
    .TAG_W  (TW),
    .CNT_W  (CW)
  ) dut (
    .sys_clk           (sys_clk),
    .sys_rst_n         (sys_rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_code           (in_code),
    .in_tag            (in_tag),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_tag           (out_tag),
    .out_corrected     (out_corrected),
    .out_uncorrectable (out_uncorrectable),
    .out_syndrome      (out_syndrome),
    .cnt_clr           (cnt_clr),
    .cnt_corrected     (cnt_corrected),
    .cnt_uncorrectable (cnt_uncorrectable),
    .log_clr           (log_clr),
    .log_valid         (log_valid),
    .log_tag           (log_tag),
    .log_syndrome      (log_syndrome)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Reference encoder built position by position.
  function automatic logic [71:0] encode(input logic [63:0] d);
    logic [71:0] cw;
    logic [6:0]  h;
    int k;
    cw = '0;
    k = 0;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[k];
        k++;
      end
    end
    h = '0;
    for (int j = 0; j < 7; j++) begin
      for (int p = 1; p < 72; p++) begin
        if (((p >> j) & 1) == 1) h[j] = h[j] ^ cw[p];
      end
    end
    return {(^d) ^ (^h), h, d};
  endfunction

  task automatic send(input logic [71:0] code, input logic [15:0] tag);
    int n;
    n = 0;
    in_code  = code;
    in_tag   = tag;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("send_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic recv(input string name, input logic [63:0] d, input logic [15:0] tag,
                      input logic corr, input logic unc, input logic [7:0] syn);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, out_data, d);
    chk({name, "_tag"}, out_tag, tag);
    chk({name, "_corr"}, out_corrected, corr);
    chk({name, "_unc"}, out_uncorrectable, unc);
    chk({name, "_syn"}, out_syndrome, syn);
    step();
  endtask

  logic [63:0] d1;
  logic [71:0] c1;
  logic [71:0] fb;
  logic [63:0] d4 [4];
  logic [71:0] c4 [4];

  initial begin
    d1 = 64'h0123_4567_89AB_CDEF;
    c1 = encode(d1);
    for (int k = 0; k < 4; k++) begin
      d4[k] = {16'hBEE0 + 16'(k), 48'h5A5A_0F0F_1234};
      c4[k] = encode(d4[k]);
    end

    // Reset state
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {out_corrected, out_uncorrectable}, 0);
    chk("rst_cnt_c", cnt_corrected, 0);
    chk("rst_cnt_u", cnt_uncorrectable, 0);
    chk("rst_log_valid", log_valid, 0);
    sys_rst_n = 1'b1;
    step();

    // 1: clean word, two-cycle latency
    send(c1, 16'hA001);
    chk("t1_lat1", out_valid, 0);
    step();
    chk("t1_lat2", out_valid, 1);
    recv("t1", d1, 16'hA001, 1'b0, 1'b0, 8'h00);
    chk("t1_cnt_c", cnt_corrected, 0);

    // 2: data bit 5 (position 10) flipped
    fb = c1 ^ (72'd1 << 5);
    send(fb, 16'hA002);
    recv("t2", d1, 16'hA002, 1'b1, 1'b0, 8'h8A);
    chk("t2_cnt_c", cnt_corrected, 1);

    // Overall parity bit flipped
    fb = c1 ^ (72'd1 << 71);
    send(fb, 16'hA0A1);
    recv("tpar", d1, 16'hA0A1, 1'b1, 1'b0, 8'h80);
    chk("tpar_cnt_c", cnt_corrected, 2);

    // Check bit 0 (position 1) flipped
    fb = c1 ^ (72'd1 << 64);
    send(fb, 16'hA0A2);
    recv("tchk", d1, 16'hA0A2, 1'b1, 1'b0, 8'h81);
    chk("tchk_cnt_c", cnt_corrected, 3);

    // 3: data bits 0 and 1 flipped -> double error, raw data out
    fb = c1 ^ 72'h3;
    send(fb, 16'hA003);
    recv("t3", d1 ^ 64'h3, 16'hA003, 1'b0, 1'b1, 8'h06);
    chk("t3_cnt_u", cnt_uncorrectable, 1);
    chk("t3_log_valid", log_valid, LOG_EN ? 1 : 0);
    chk("t3_log_tag", log_tag, LOG_EN ? 16'hA003 : 16'h0);
    chk("t3_log_syn", log_syndrome, LOG_EN ? 8'h06 : 8'h0);

    // Odd error with syndrome 72 beyond the last position: uncorrectable;
    // the held log entry is kept.
    fb = c1 ^ (72'd1 << 70) ^ (72'd1 << 67) ^ (72'd1 << 71);
    send(fb, 16'hA004);
    recv("tbig", d1, 16'hA004, 1'b0, 1'b1, 8'hC8);
    chk("tbig_cnt_u", cnt_uncorrectable, 2);
    chk("tbig_log_tag", log_tag, LOG_EN ? 16'hA003 : 16'h0);
    log_clr = 1'b1;
    step();
    log_clr = 1'b0;
    chk("logclr_valid", log_valid, 0);

    // 4: backpressure, four words, none lost
    out_ready = 1'b0;
    send(c4[0], 16'hB000);
    send(c4[1], 16'hB001);
    in_code  = c4[2];
    in_tag   = 16'hB002;
    in_valid = 1'b1;
    chk("t4_stall", in_ready, 0);
    repeat (4) step();
    chk("t4_stall_hold", in_ready, 0);
    chk("t4_hold_valid", out_valid, 1);
    chk("t4_hold_data", out_data, d4[0]);
    out_ready = 1'b1;
    #1;
    chk("t4_release", in_ready, 1);
    chk("t4_w0", {out_tag, out_data}, {16'hB000, d4[0]});
    step();
    in_code = c4[3];
    in_tag  = 16'hB003;
    chk("t4_w1", {out_tag, out_data}, {16'hB001, d4[1]});
    step();
    in_valid = 1'b0;
    chk("t4_w2", {out_tag, out_data}, {16'hB002, d4[2]});
    step();
    chk("t4_w3", {out_tag, out_data}, {16'hB003, d4[3]});
    step();
    chk("t4_empty", out_valid, 0);
    chk("t4_cnt", {cnt_corrected, cnt_uncorrectable}, {2'd3, 2'd2});

    // 5: saturation at 3, then clear wins over increment
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("t5_clr", {cnt_corrected, cnt_uncorrectable}, 0);
    fb = c1 ^ (72'd1 << 5);
    for (int k = 0; k < 5; k++) begin
      send(fb, 16'hC000 + 16'(k));
      recv("t5", d1, 16'hC000 + 16'(k), 1'b1, 1'b0, 8'h8A);
      chk("t5_cnt_c", cnt_corrected, (k < 3) ? (k + 1) : 3);
    end
    send(fb, 16'hC005);
    step();
    chk("t5_6th_valid", out_valid, 1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("t5_clr_wins", cnt_corrected, 0);
    chk("t5_6th_gone", out_valid, 0);

    // 6: reset with two words in flight
    fb = c1 ^ 72'h3;
    send(fb, 16'hD000);
    recv("t6_pre", d1 ^ 64'h3, 16'hD000, 1'b0, 1'b1, 8'h06);
    chk("t6_pre_cnt_u", cnt_uncorrectable, 1);
    chk("t6_pre_log", log_valid, LOG_EN ? 1 : 0);
    out_ready = 1'b0;
    send(c1, 16'hD001);
    send(c1, 16'hD002);
    chk("t6_inflight", out_valid, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_cnt", {cnt_corrected, cnt_uncorrectable}, 0);
    chk("t6_rst_log", log_valid, 0);
    step();
    sys_rst_n = 1'b1;
    out_ready = 1'b1;
    chk("t6_ready_after", in_ready, 1);
    send(c1, 16'hD003);
    chk("t6_no_ghost", out_valid, 0);
    recv("t6", d1, 16'hD003, 1'b0, 1'b0, 8'h00);
    chk("t6_drained", out_valid, 0);
    chk("t6_cnt", {cnt_corrected, cnt_uncorrectable}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
